// File: rtl/ram_rd_pkg.sv
// ---------------------------------------------------------------------------
// ram_rd_pkg
// Shared definitions for the RAM stream reader:
//   - FSM state encoding (IDLE / READ / DRAIN)
//   - depth and count width of the small output FIFO that absorbs the
//     one-cycle RAM read latency.
// Optional feature macro used by the reader: RAM_RD_STRIDE_EN.
// ---------------------------------------------------------------------------
package ram_rd_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_READ  = S_READ,
    ST_DRAIN = S_DRAIN
  } rd_state_e;

  // Two entries are enough to keep one beat per cycle flowing with a
  // single-cycle RAM latency and a registered issue decision.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// ---------------------------------------------------------------------------
// ram_rd_skid_fifo
// Two-entry FIFO carrying {last, data} words from the RAM read port to the
// output stream.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write one word (caller guarantees a free slot)
//   pop             remove the head word (ignored when empty)
//   pop_data        head word (stale contents when empty)
//   count           number of stored words (0..2)
//   empty           count == 0
// ---------------------------------------------------------------------------
module ram_rd_skid_fifo
  import ram_rd_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  logic [WIDTH-1:0]      entries [FIFO_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_push  = push;
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + FIFO_CNT_W'(1);
      2'b01:   count_d = count_q - FIFO_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // One register per slot; a slot is written only when the write pointer
  // points at it.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_q, entry_d;

    always_comb begin
      entry_d = entry_q;
      if (do_push && (int'(wr_ptr_q) == gi)) begin
        entry_d = push_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign entries[gi] = entry_q;
  end

  assign pop_data = entries[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
// Read-side master for a pseudo dual-port RAM. Takes a burst command
// (start address, length), drives the RAM read port, absorbs the one-cycle
// dob latency in a 2-entry FIFO and returns the words as a valid/ready
// stream with the final beat marked by m_last.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_addr, cmd_len                burst start address and word count
//   cmd_stride (RAM_RD_STRIDE_EN)    address step per read
//   ram_enb, ram_addrb, ram_dob      RAM read port (dob valid 1 cycle later)
//   m_valid/m_ready, m_data, m_last  output stream
//   busy                             state is not IDLE
//   done                             one-cycle pulse after a burst completes
//
// Optional feature: define RAM_RD_STRIDE_EN to add cmd_stride; otherwise
// the address steps by 1.
// ---------------------------------------------------------------------------
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
`ifdef RAM_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;
  logic                  live_q;
  logic [ADDR_WIDTH-1:0] stride;

  logic                  issue;
  logic                  pop;
  logic [2:0]            occ;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic                  fifo_empty;
  logic                  cmd_fire;

`ifdef RAM_RD_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;

  always_comb begin
    stride_d = stride_q;
    if (cmd_fire && (cmd_len != '0)) begin
      stride_d = cmd_stride;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else begin
      stride_q <= stride_d;
    end
  end

  assign stride = stride_q;
`else
  assign stride = ADDR_WIDTH'(1);
`endif

  // live_q keeps cmd_ready low while reset is held and rises on the first
  // clock after release.
  assign cmd_ready = live_q && (state_q == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign pop       = m_valid && m_ready;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    done_d          = 1'b0;
    issue           = 1'b0;
    // Words stored plus the one possibly still coming out of the RAM.
    occ             = {1'b0, fifo_cnt} + {2'b00, inflight_q};

    if ((state_q == ST_READ) && (rem_q != '0)) begin
      if (occ < 3'(FIFO_DEPTH)) begin
        issue = 1'b1;
      end else if ((occ == 3'(FIFO_DEPTH)) && pop) begin
        issue = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_READ;
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d = addr_q + stride;
          rem_d  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The last beat can only leave after the last read was issued,
        // so its handshake always lands here.
        if (pop && m_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    inflight_d      = issue;
    inflight_last_d = issue && (rem_q == LEN_WIDTH'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      live_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
      live_q          <= 1'b1;
    end
  end

  // dob is captured the cycle after the issue, tagged with whether that
  // read was the final one of the burst.
  ram_rd_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({inflight_last_q, ram_dob}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

  assign ram_enb   = issue;
  assign ram_addrb = addr_q;
  assign m_valid   = !fifo_empty;
  assign m_data    = m_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign m_last    = m_valid && fifo_head[DATA_WIDTH];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_stream_reader
// Directed bench for ram_stream_reader with a behavioural 1-cycle-latency
// RAM preloaded with mem[i] = i + 0x10.
// ---------------------------------------------------------------------------
module tb_ram_stream_reader;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int LW = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
`ifdef RAM_RD_STRIDE_EN
  logic [AW-1:0] cmd_stride = AW'(1);
`endif
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];
  int            stride = 1;
  int            n_pass = 0;
  int            n_check = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  ram_stream_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
`ifdef RAM_RD_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dob   (ram_dob),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_check++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // mode 0: m_ready always high; mode 1: m_ready high one cycle in three.
  // stop_after != 0 returns (mid-cycle) once that many beats were taken.
  task automatic run_burst(input int addr, input int len, input int mode, input int stop_after);
    int idx, issues, beats, first_enb, first_valid, viol, held, budget, early_done, exp_a;
    logic [DW-1:0] held_data;
    logic          held_last;
    issues = 0; beats = 0; first_enb = -1; first_valid = -1; viol = 0;
    held = 0; early_done = 0; held_data = '0; held_last = 1'b0;
    $display("burst addr=%0d len=%0d mode=%0d stride=%0d", addr, len, mode, stride);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    m_ready   = (mode == 0);
    #1 check("cmd_ready_idle", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    idx = 0;
    budget = 4 * len + 20;
    while (beats < len && idx < budget) begin
      @(negedge clk);
      idx++;
      m_ready = (mode == 0) ? 1'b1 : (idx % 3 == 0);
      #1;
      if (stop_after != 0 && beats == stop_after) return;
      if (idx == 1) begin
        check("busy_in_burst", 32'(busy), 1);
        check("cmd_ready_busy", 32'(cmd_ready), 0);
      end
      if (ram_enb) begin
        if (first_enb < 0) first_enb = idx;
        if ((issues - beats) == 2 && !(m_valid && m_ready)) viol++;
        check($sformatf("addrb[%0d]", issues), 32'(ram_addrb), (addr + issues * stride) % DEPTH);
        issues++;
      end
      if (m_valid && first_valid < 0) first_valid = idx;
      if (held != 0) begin
        check("hold_valid", 32'(m_valid), 1);
        check("hold_data", 32'(m_data), 32'(held_data));
        check("hold_last", 32'(m_last), 32'(held_last));
      end
      held = 0;
      if (done) early_done++;
      if (m_valid && m_ready) begin
        exp_a = (addr + beats * stride) % DEPTH;
        $display("beat %0d data=%02h last=%0b", beats, m_data, m_last);
        check($sformatf("data[%0d]", beats), 32'(m_data), 32'(mem[exp_a]));
        check($sformatf("last[%0d]", beats), 32'(m_last), (beats == len - 1) ? 1 : 0);
        beats++;
      end else if (m_valid) begin
        held = 1;
        held_data = m_data;
        held_last = m_last;
      end
    end
    check("beat_count", beats, len);
    check("issue_count", issues, len);
    check("first_enb_cycle", first_enb, 1);
    check("first_valid_cycle", first_valid, 3);
    check("issue_rule_viol", viol, 0);
    check("done_early", early_done, 0);
    @(negedge clk);
    #1;
    check("done_pulse", 32'(done), 1);
    check("busy_after", 32'(busy), 0);
    check("cmd_ready_after", 32'(cmd_ready), 1);
    @(negedge clk);
    #1 check("done_cleared", 32'(done), 0);
  endtask

  initial begin
    int act;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 16);

    // Reset state while rst_n is low.
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_ram_enb", 32'(ram_enb), 0);
    check("rst_ram_addrb", 32'(ram_addrb), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("cmd_ready_post_rst", 32'(cmd_ready), 1);

    // Basic burst, full rate.
    run_burst(4, 3, 0, 0);
    // Backpressure.
    run_burst(8, 8, 1, 0);
    // Address wrap.
    run_burst(62, 4, 0, 0);
    // Whole RAM, maximum length.
    run_burst(0, 64, 0, 0);

    // Zero-length command.
    $display("burst addr=5 len=0");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = AW'(5); cmd_len = '0; m_ready = 1'b1;
    #1 check("zl_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    check("zl_done", 32'(done), 1);
    check("zl_busy", 32'(busy), 0);
    check("zl_cmd_ready_after", 32'(cmd_ready), 1);
    act = 0;
    if (ram_enb || m_valid) act++;
    repeat (4) begin
      @(negedge clk);
      #1 if (ram_enb || m_valid || done || !cmd_ready) act++;
    end
    check("zl_activity", act, 0);

    // Reset in the middle of a long burst.
    run_burst(10, 16, 0, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ram_enb", 32'(ram_enb), 0);
    check("mid_rst_addrb", 32'(ram_addrb), 0);
    check("mid_rst_m_valid", 32'(m_valid), 0);
    check("mid_rst_m_data", 32'(m_data), 0);
    check("mid_rst_m_last", 32'(m_last), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 0);
    check("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (8) begin
      @(negedge clk);
      #1 if (m_valid || ram_enb || done || busy) act++;
    end
    check("post_rst_quiet", act, 0);
    run_burst(20, 2, 0, 0);

`ifdef RAM_RD_STRIDE_EN
    stride = 3;
    cmd_stride = AW'(3);
    run_burst(0, 4, 0, 0);
    stride = 0;
    cmd_stride = '0;
    run_burst(7, 3, 1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side master for the pseudo dual-port RAM. It accepts a burst command (base address, length), drives the RAM read port (enb/addrb) and absorbs the fixed 1-cycle dob latency.
- Returns the words as a valid/ready stream with last-beat marking and full backpressure support.
- Sits between a RAM instance and downstream compute/DMA consumers. It is the counterpart of whatever fills the RAM through port A.

Parameters:
- DATA_WIDTH, 8, RAM word width / stream data width
- ADDR_WIDTH, 6, RAM address width; RAM depth = 1<<ADDR_WIDTH
- LEN_WIDTH, ADDR_WIDTH+1, burst length width; lengths 0..(1<<ADDR_WIDTH) are representable

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  ADDR_WIDTH  burst start address
- cmd_len  in  LEN_WIDTH  number of words to read
- ram_enb  out  1  to RAM enb
- ram_addrb  out  ADDR_WIDTH  to RAM addrb
- ram_dob  in  DATA_WIDTH  from RAM dob; valid the cycle after ram_enb
- m_valid  out  1  stream data valid
- m_ready  in  1  stream consumer ready
- m_data  out  DATA_WIDTH  stream data
- m_last  out  1  marks the final beat of a burst
- busy  out  1  high whenever state is not IDLE
- done  out  1  1-cycle pulse at burst completion

Behaviour:
- One clock: clk. Reset is asynchronous, active-low (rst_n).
- Reset values: cmd_ready=0 while rst_n low, then 1. ram_enb=0, ram_addrb=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. Counters, FIFO and state are cleared.
- Reset mid-burst: everything is dropped immediately. No residual beats are emitted after release.
- FSM states: IDLE, READ, DRAIN.
  - IDLE→READ on cmd_valid&&cmd_ready with cmd_len!=0. At that edge, latch the address and set the remaining-issue count to cmd_len.
  - IDLE with cmd_len==0: accept the command, no RAM access, no beats, done pulses the next cycle, stay in IDLE.
  - READ→DRAIN when the last read is issued.
  - DRAIN→IDLE on the m_valid&&m_ready handshake with m_last=1. done=1 in the following cycle.
- Issue rule: ram_enb is high (combinational) when all of the following hold:
  - state is READ;
  - remaining!=0;
  - (fifo_cnt + inflight) < 2, or that sum ==2 and a pop occurs this cycle.
- inflight is a 1-bit register equal to the previous cycle's ram_enb. On an issue, the address increments by 1 and remaining decrements.
- ram_dob is pushed into a 2-entry FIFO in the cycle after an issue. The FIFO can never overflow.
- Address wraps modulo 2^ADDR_WIDTH (e.g. 63→0 when ADDR_WIDTH=6).
- Latency: command accepted at edge C → ram_enb in cycle C+1 → first m_valid in cycle C+3.
- Throughput: 1 beat/cycle while m_ready is held high.
- Stream rules: m_data and m_last stay stable while m_valid&&!m_ready. m_valid never drops without a handshake.
- m_last is asserted on beat number cmd_len only. Exactly cmd_len beats are emitted per burst.
- cmd_valid while busy is ignored; cmd_ready=0.

Optional Feature:
- Macro RAM_RD_STRIDE_EN.
- Defined: adds input cmd_stride[ADDR_WIDTH-1:0], latched with the command. The address increments by the stride per issue, modulo 2^ADDR_WIDTH. Stride 0 re-reads the same word cmd_len times.
- Undefined: port absent, stride fixed at 1.

Decomposition:
- Package ram_rd_pkg: FSM state encoding localparams (IDLE/READ/DRAIN) and FIFO depth constant (2).
- One sub-module: ram_rd_skid_fifo, a 2-entry DATA_WIDTH+1 FIFO carrying data+last, with push/pop/count.

Test Plan:
- Basic burst: cmd_addr=4, cmd_len=3, RAM preloaded mem[i]=i+0x10, m_ready=1 → ram_addrb 4,5,6 on consecutive cycles; beats 0x14,0x15,0x16; m_last on 0x16; done 1 cycle later; first m_valid 3 cycles after accept.
- Backpressure: cmd_len=8, m_ready toggling 1-0-0-1… → all 8 words in order, data stable during stalls, ram_enb never issued with fifo_cnt+inflight==2 without a pop.
- Wrap: cmd_addr=62, cmd_len=4 → addresses 62,63,0,1; beats match.
- Zero length: cmd_len=0 → no ram_enb, no m_valid, done pulse next cycle, cmd_ready stays high.
- Reset mid-op: cmd_len=16, assert rst_n=0 after 5 beats → all outputs at reset values immediately; no beats after release; new cmd_len=2 completes normally.
- With RAM_RD_STRIDE_EN: cmd_addr=0, cmd_len=4, stride=3 → addresses 0,3,6,9.
